ram_sp_sync: RTL and testbench
==============================

Name: ram_sp_sync

Overview:
Parametrised single-port synchronous RAM. Successor to the team's 1K x 8 asynchronous chip-select RAM, with these additions:
- clocked read/write;
- configurable width, depth and read latency;
- hardware zero-initialisation sweep after reset;
- a read-valid strobe and an error strobe.

It serves as the general scratch/buffer memory behind bus slaves and test harnesses.

Parameters:
DATA_W, 8, data word width in bits (1..64)
ADDR_W, 10, address width in bits
DEPTH, 1<<ADDR_W, number of words implemented; must satisfy 2 <= DEPTH <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register stage)

Ports:
clk        input   1        clock; all logic on rising edge
rst_n      input   1        synchronous active-low reset
cs         input   1        chip select; request qualified only when cs=1
rd         input   1        read request
wr         input   1        write request
addr       input   ADDR_W   word address
din        input   DATA_W   write data
dout       output  DATA_W   read data; holds last read value
dout_vld   output  1        one-cycle pulse when dout carries new read data
busy       output  1        1 while the init sweep runs; requests ignored
err        output  1        one-cycle pulse on an illegal request
init_done  output  1        1 once the sweep has completed, until next reset

Behaviour:
- Reset (rst_n=0 sampled at clk): dout=0, dout_vld=0, err=0, init_done=0, busy=1, sweep pointer=0, latency pipeline cleared, FSM -> INIT.
- Reset asserted mid-sweep or mid-read: sweep restarts at address 0 and in-flight reads are discarded. No dout_vld may follow the reset.
- FSM INIT:
  - Writes 0 to mem[ptr] each cycle; ptr increments.
  - When ptr=DEPTH-1 has been written: next state IDLE; busy=0 and init_done=1 from the following cycle.
  - Total: DEPTH cycles of busy after rst_n rises.
  - All cs/rd/wr ignored; err stays 0.
- FSM IDLE, evaluated per cycle:
  - cs=0, or rd=wr=0: no operation.
  - cs&wr&!rd, addr<DEPTH: mem[addr]<=din at this edge.
  - cs&rd&!wr, addr<DEPTH: mem[addr] captured at this edge. dout updates and dout_vld=1 exactly RD_LAT edges after the request edge.
  - cs&rd&wr: no memory access; err=1 on the next cycle.
  - addr>=DEPTH (only possible when DEPTH<2**ADDR_W):
    - write: discarded.
    - read: returns 0 with the normal dout_vld timing.
    - either case: err=1 on the next cycle.
- Back-to-back: one request per cycle is accepted at full throughput. A write at cycle N followed by a read of the same address at N+1 returns the new data.
- dout is stable between dout_vld pulses. dout_vld is never asserted for writes or no-ops.
- RD_LAT=2: a second register between the array and dout; reads remain fully pipelined.

Optional Feature:
RAM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed from din on write. The init sweep writes parity 0 for zero data.
  - On read, parity is rechecked. Output par_err (1 bit, reset 0) pulses together with dout_vld when stored parity mismatches the data.
  - A debug input par_inj (1 bit) inverts the stored parity bit on writes taken while par_inj=1.
- Undefined: par_err and par_inj do not exist, no extra storage is inferred, and behaviour is otherwise identical.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=4, DEPTH=12, RD_LAT=1 unless stated.
1. Release rst_n -> busy=1 for exactly 12 cycles, then init_done=1. Read all addresses 0..11 -> dout=0x00, dout_vld pulse one cycle after each request.
2. Write 0xA5 @3, read @3 on the next cycle -> dout=0xA5 with dout_vld one cycle later. Repeat with RD_LAT=2 -> dout=0xA5 two cycles after the read.
3. Stream writes addr i=0..11 data 0x10+i, then 12 consecutive reads -> 12 consecutive dout_vld pulses with data 0x10..0x1B in order.
4. Request cs=1, rd=1, wr=1 @5 -> err pulse, mem[5] unchanged, no dout_vld. Write @13 -> err pulse, mem unchanged. Read @14 -> dout=0x00, dout_vld and err both pulse.
5. Request cs=1, wr=1, din=0xFF during the init sweep -> ignored, err=0, location still 0x00 afterwards. Assert rst_n=0 at sweep cycle 6 -> busy restarts and 12 full cycles follow release.
6. With RAM_PARITY_EN defined: write 0x3C @2 with par_inj=1, then read @2 -> dout=0x3C and par_err=1. Rewrite with par_inj=0 and read -> par_err=0.

Source files
------------

// File: rtl/ram_sp_sync.sv
// ram_sp_sync: parametrised single-port synchronous RAM.
// After reset, a hardware sweep writes zero to every word. The RAM reports busy
// while the sweep runs. Reads have a configurable latency of 1 or 2 cycles, and
// dout_vld pulses when dout carries new read data. err pulses one cycle after an
// illegal request: rd and wr together, or an address at or above DEPTH.
// Optional feature, guarded by the macro RAM_PARITY_EN:
//   - each word stores an even-parity bit;
//   - par_err pulses with dout_vld on a parity mismatch;
//   - par_inj corrupts the stored parity bit of a write, for fault injection.
module ram_sp_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
`ifdef RAM_PARITY_EN
  input  logic              par_inj,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              busy,
  output logic              err,
  output logic              init_done
);

  localparam int               IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              do_wr, do_rd, req_err;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              s1_vld;
  logic [DATA_W-1:0] s1_data;
`ifdef RAM_PARITY_EN
  logic              mem_wpar;
  logic              mem_par [DEPTH];
  logic              s1_perr;
`endif

  assign idx = addr[IDX_W-1:0];

  // The range check exists only when part of the address space is unpopulated.
  generate
    if (DEPTH < (1 << ADDR_W)) begin : g_partial
      localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
      assign in_range = ({1'b0, addr} < DEPTH_X);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  // State register: reset always returns to the init sweep.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Next-state logic: leave INIT once the last word has been cleared.
  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && ptr == LAST) state_nxt = S_IDLE;
  end

  // Output logic: status flags, request decode and the shared write-port mux.
  always_comb begin
    busy      = (state == S_INIT);
    init_done = (state == S_IDLE);
    do_wr     = (state == S_IDLE) && cs && wr && !rd && in_range;
    do_rd     = (state == S_IDLE) && cs && rd && !wr;
    req_err   = (state == S_IDLE) && cs && ((rd && wr) || ((rd ^ wr) && !in_range));
    mem_we    = rst_n && (busy || do_wr);
    mem_waddr = busy ? ptr : idx;
    mem_wdata = busy ? '0 : din;
`ifdef RAM_PARITY_EN
    mem_wpar  = busy ? 1'b0 : ((^din) ^ par_inj);
`endif
  end

  // Sweep pointer: steps through every word while in INIT.
  always_ff @(posedge clk) begin
    if (!rst_n)                ptr <= '0;
    else if (state == S_INIT)  ptr <= ptr + 1'b1;
  end

  // Array write port, shared by the init sweep and user writes.
  // NOTE: the array itself has no reset; the post-reset sweep is what clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
`ifdef RAM_PARITY_EN
      mem_par[mem_waddr] <= mem_wpar;
`endif
    end
  end

  // First read stage: capture array data (0 when out of range) and the error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
      err     <= 1'b0;
`ifdef RAM_PARITY_EN
      s1_perr <= 1'b0;
`endif
    end else begin
      s1_vld <= do_rd;
      err    <= req_err;
      if (do_rd) begin
        s1_data <= in_range ? mem[idx] : '0;
`ifdef RAM_PARITY_EN
        s1_perr <= in_range && (mem_par[idx] ^ (^mem[idx]));
`endif
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_vld;
      logic [DATA_W-1:0] s2_data;
`ifdef RAM_PARITY_EN
      logic              s2_perr;
`endif
      // Second read stage: extra output register, still one read per cycle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_vld  <= 1'b0;
          s2_data <= '0;
`ifdef RAM_PARITY_EN
          s2_perr <= 1'b0;
`endif
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_data <= s1_data;
`ifdef RAM_PARITY_EN
            s2_perr <= s1_perr;
`endif
          end
        end
      end
      assign dout     = s2_data;
      assign dout_vld = s2_vld;
`ifdef RAM_PARITY_EN
      assign par_err  = s2_vld && s2_perr;
`endif
    end else begin : g_lat1
      assign dout     = s1_data;
      assign dout_vld = s1_vld;
`ifdef RAM_PARITY_EN
      assign par_err  = s1_vld && s1_perr;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ram_sp_sync.sv
// Testbench for ram_sp_sync. Two instances share one stimulus stream, one with
// RD_LAT=1 and one with RD_LAT=2. Expected values come from an array model of
// the memory plus the request rules. Define RAM_PARITY_EN to include the parity test.
module tb_ram_sp_sync;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, cs, rd, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout1, dout2;
  logic          vld1, vld2, busy1, busy2, err1, err2, done1, done2;
`ifdef RAM_PARITY_EN
  logic          par_inj = 1'b0;
  logic          perr1, perr2;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  ram_sp_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .din(din),
`ifdef RAM_PARITY_EN
    .par_inj(par_inj), .par_err(perr1),
`endif
    .dout(dout1), .dout_vld(vld1), .busy(busy1), .err(err1), .init_done(done1));

  ram_sp_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .din(din),
`ifdef RAM_PARITY_EN
    .par_inj(par_inj), .par_err(perr2),
`endif
    .dout(dout2), .dout_vld(vld2), .busy(busy2), .err(err2), .init_done(done2));

  // Drive one request, let one rising edge take it, return at the following falling edge.
  task automatic cycle(input logic c, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    cs = c; rd = r; wr = w; addr = a; din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count falling edges with busy high; call right after releasing rst_n.
  task automatic wait_sweep(output int n);
    n = 0;
    for (int i = 0; i < 100 && busy1; i++) begin
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic test_reset;
    int n;
    cs = 0; rd = 0; wr = 0; addr = '0; din = '0; rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy1, done1, vld1, err1, dout1} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_state1: got busy/done/vld/err/dout=%b%b%b%b/%h expected 1000/00", busy1, done1, vld1, err1, dout1); end
    checks++; if ({busy2, done2, vld2, err2, dout2} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_state2: got busy/done/vld/err/dout=%b%b%b%b/%h expected 1000/00", busy2, done2, vld2, err2, dout2); end
    rst_n = 1;
    wait_sweep(n);
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL sweep_len: got %0d expected %0d", n, DEPTH); end
    checks++; if ({done1, done2, busy2} !== 3'b110) begin
      errors++; $display("FAIL init_done: got done1/done2/busy2=%b%b%b expected 110", done1, done2, busy2); end
    for (int a = 0; a < DEPTH; a++) begin
      cycle(1'b1, 1'b1, 1'b0, AW'(a), 8'h00);
      checks++; if ({vld1, err1, dout1} !== {1'b1, 1'b0, ref_mem[a]}) begin
        errors++; $display("FAIL zero_read@%0d: got vld/err/dout=%b%b/%h expected 10/%h", a, vld1, err1, dout1, ref_mem[a]); end
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL idle_vld: got %b expected 0", vld1); end
  endtask

  task automatic test_write_read;
    cycle(1'b1, 1'b0, 1'b1, 4'd3, 8'hA5);
    ref_mem[3] = 8'hA5;
    checks++; if ({vld1, vld2, err1} !== 3'b000) begin
      errors++; $display("FAIL write_no_vld: got vld1/vld2/err=%b%b%b expected 000", vld1, vld2, err1); end
    cycle(1'b1, 1'b1, 1'b0, 4'd3, 8'h00);
    checks++; if ({vld1, dout1} !== {1'b1, ref_mem[3]}) begin
      errors++; $display("FAIL wr_rd_lat1: got vld/dout=%b/%h expected 1/%h", vld1, dout1, ref_mem[3]); end
    checks++; if (vld2 !== 1'b0) begin errors++; $display("FAIL wr_rd_lat2_early: got vld %b expected 0", vld2); end
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    checks++; if ({vld2, dout2} !== {1'b1, ref_mem[3]}) begin
      errors++; $display("FAIL wr_rd_lat2: got vld/dout=%b/%h expected 1/%h", vld2, dout2, ref_mem[3]); end
    checks++; if ({vld1, dout1} !== {1'b0, ref_mem[3]}) begin
      errors++; $display("FAIL dout_hold: got vld/dout=%b/%h expected 0/%h", vld1, dout1, ref_mem[3]); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 1'b1, AW'(i), DW'(8'h10 + i));
      ref_mem[i] = DW'(8'h10 + i);
      checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL stream_wr_vld@%0d: got %b expected 0", i, vld1); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b1, 1'b0, AW'(i), 8'h00);
      checks++; if ({vld1, dout1} !== {1'b1, ref_mem[i]}) begin
        errors++; $display("FAIL stream_rd1@%0d: got vld/dout=%b/%h expected 1/%h", i, vld1, dout1, ref_mem[i]); end
      if (i > 0) begin
        checks++; if ({vld2, dout2} !== {1'b1, ref_mem[i-1]}) begin
          errors++; $display("FAIL stream_rd2@%0d: got vld/dout=%b/%h expected 1/%h", i - 1, vld2, dout2, ref_mem[i-1]); end
      end
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    checks++; if ({vld2, dout2} !== {1'b1, ref_mem[DEPTH-1]}) begin
      errors++; $display("FAIL stream_rd2_last: got vld/dout=%b/%h expected 1/%h", vld2, dout2, ref_mem[DEPTH-1]); end
  endtask

  task automatic test_errors;
    cycle(1'b1, 1'b1, 1'b1, 4'd5, 8'h77);
    checks++; if ({err1, vld1} !== 2'b10) begin errors++; $display("FAIL rdwr_err: got err/vld=%b%b expected 10", err1, vld1); end
    cycle(1'b1, 1'b1, 1'b0, 4'd5, 8'h00);
    checks++; if ({err1, vld1, dout1} !== {1'b0, 1'b1, ref_mem[5]}) begin
      errors++; $display("FAIL rdwr_unchanged: got err/vld/dout=%b%b/%h expected 01/%h", err1, vld1, dout1, ref_mem[5]); end
    cycle(1'b1, 1'b0, 1'b1, 4'd13, 8'h99);
    checks++; if ({err1, vld1} !== 2'b10) begin errors++; $display("FAIL oor_wr_err: got err/vld=%b%b expected 10", err1, vld1); end
    cycle(1'b1, 1'b1, 1'b0, 4'd14, 8'h00);
    checks++; if ({err1, vld1, dout1} !== {1'b1, 1'b1, 8'h00}) begin
      errors++; $display("FAIL oor_rd: got err/vld/dout=%b%b/%h expected 11/00", err1, vld1, dout1); end
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    checks++; if ({err1, vld1, err2} !== 3'b000) begin
      errors++; $display("FAIL err_pulse: got err1/vld1/err2=%b%b%b expected 000", err1, vld1, err2); end
  endtask

  task automatic test_random;
    // Both outputs last carried the out-of-range read of address 14, i.e. 0x00.
    logic [DW-1:0] e1 = 8'h00, e2 = 8'h00, p_data = 8'h00;
    logic          p_vld = 1'b0;
    for (int k = 0; k < 300; k++) begin
      logic          c, r, w, ev, ee;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      c = ($urandom_range(0, 3) != 0);
      r = 1'($urandom);
      w = 1'($urandom);
      a = AW'($urandom_range(0, 15));
      d = DW'($urandom);
      ev = c && r && !w;
      ee = c && ((r && w) || ((r != w) && (a >= DEPTH)));
      if (ev) e1 = (a < DEPTH) ? ref_mem[a] : 8'h00;
      if (c && w && !r && a < DEPTH) ref_mem[a] = d;
      cycle(c, r, w, a, d);
      checks++; if ({vld1, err1, dout1} !== {ev, ee, e1}) begin
        errors++; $display("FAIL rand1 #%0d: got vld/err/dout=%b%b/%h expected %b%b/%h", k, vld1, err1, dout1, ev, ee, e1); end
      if (p_vld) e2 = p_data;
      checks++; if ({vld2, err2, dout2} !== {p_vld, ee, e2}) begin
        errors++; $display("FAIL rand2 #%0d: got vld/err/dout=%b%b/%h expected %b%b/%h", k, vld2, err2, dout2, p_vld, ee, e2); end
      p_vld  = ev;
      p_data = e1;
    end
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_init_ignore;
    int  n;
    logic seen;
    rst_n = 0; cs = 1; rd = 0; wr = 1; addr = 4'd4; din = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 100 && busy1; i++) begin
      if (err1 || vld1) seen = 1'b1;
      n++;
      @(posedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL busy_wr_len: got %0d expected %0d", n, DEPTH); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL busy_wr_strobe: got err/vld during sweep expected none"); end
    cycle(1'b1, 1'b1, 1'b0, 4'd4, 8'h00);
    checks++; if ({vld1, dout1} !== {1'b1, ref_mem[4]}) begin
      errors++; $display("FAIL busy_wr_ignored: got vld/dout=%b/%h expected 1/%h", vld1, dout1, ref_mem[4]); end
    // Reset again at sweep cycle 6: the sweep must restart from scratch.
    rst_n = 0; cs = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({busy1, done1} !== 2'b10) begin errors++; $display("FAIL midsweep_rst: got busy/done=%b%b expected 10", busy1, done1); end
    rst_n = 1;
    wait_sweep(n);
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL midsweep_len: got %0d expected %0d", n, DEPTH); end
    // Reset right after a read: the RD_LAT=2 read in flight must be dropped.
    cycle(1'b1, 1'b1, 1'b0, 4'd4, 8'h00);
    rst_n = 0; cs = 0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({vld1, vld2} !== 2'b00) begin errors++; $display("FAIL midread_rst: got vld1/vld2=%b%b expected 00", vld1, vld2); end
    @(posedge clk);
    @(negedge clk);
    checks++; if ({vld1, vld2} !== 2'b00) begin errors++; $display("FAIL midread_rst2: got vld1/vld2=%b%b expected 00", vld1, vld2); end
    rst_n = 1;
    wait_sweep(n);
    checks++; if (n !== DEPTH) begin errors++; $display("FAIL post_read_rst_len: got %0d expected %0d", n, DEPTH); end
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity;
    par_inj = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 4'd2, 8'h3C);
    par_inj = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 4'd2, 8'h00);
    checks++; if ({vld1, dout1, perr1} !== {1'b1, 8'h3C, 1'b1}) begin
      errors++; $display("FAIL par_inj: got vld/dout/par_err=%b/%h/%b expected 1/3c/1", vld1, dout1, perr1); end
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    checks++; if ({perr1, perr2, vld2} !== 3'b011) begin
      errors++; $display("FAIL par_pulse: got perr1/perr2/vld2=%b%b%b expected 011", perr1, perr2, vld2); end
    cycle(1'b1, 1'b0, 1'b1, 4'd2, 8'h3C);
    cycle(1'b1, 1'b1, 1'b0, 4'd2, 8'h00);
    checks++; if ({vld1, dout1, perr1} !== {1'b1, 8'h3C, 1'b0}) begin
      errors++; $display("FAIL par_clean: got vld/dout/par_err=%b/%h/%b expected 1/3c/0", vld1, dout1, perr1); end
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_random();
    test_init_ignore();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

endmodule
